// File: rtl/pc_control_unit.sv
// PC / pipeline-register control for a 5-stage pipeline.
// Control outputs are combinational from the current hazards; state and counters are registered.
module pc_control_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_ex_branch,
    input  logic        in_ex_branch_taken,
    input  logic        in_ex_jump,
    input  logic        in_ex_jump_reg,
    input  logic        in_id_ex_mem_read,
    input  logic [4:0]  in_id_ex_rt,
    input  logic [4:0]  in_if_id_rs,
    input  logic [4:0]  in_if_id_rt,
    input  logic        in_imem_ready,
    output logic [1:0]  out_pc_src,
    output logic        out_pc_write,
    output logic        out_if_id_write,
    output logic        out_if_id_flush,
    output logic        out_id_ex_flush,
    output logic        out_pipe_freeze,
    output logic [1:0]  out_state,
    output logic [15:0] out_redirect_count,
    output logic [15:0] out_stall_count,
    output logic        out_imem_timeout
);

    localparam logic [1:0]  ST_RUN      = 2'b00;
    localparam logic [1:0]  ST_STALL    = 2'b01;
    localparam logic [1:0]  ST_REDIRECT = 2'b10;
    localparam logic [1:0]  ST_FREEZE   = 2'b11;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    logic        redirect_s;
    logic        load_use_s;
    logic        freeze_s;
    logic [1:0]  action_s;

    logic [1:0]  state_d, state_q;
    logic [15:0] redirect_count_d, redirect_count_q;
    logic [15:0] stall_count_d, stall_count_q;
    logic [15:0] freeze_run_d, freeze_run_q;
    logic        imem_timeout_d, imem_timeout_q;

    // Hazard decode and priority resolution: freeze > redirect > load-use > run
    always_comb begin
        redirect_s = in_ex_jump_reg | in_ex_jump | (in_ex_branch & in_ex_branch_taken);
        load_use_s = in_id_ex_mem_read & (in_id_ex_rt != 5'd0) &
                     ((in_id_ex_rt == in_if_id_rs) | (in_id_ex_rt == in_if_id_rt));
        freeze_s   = ~in_imem_ready;
        if (freeze_s) begin
            action_s = ST_FREEZE;
        end else if (redirect_s) begin
            action_s = ST_REDIRECT;
        end else if (load_use_s) begin
            action_s = ST_STALL;
        end else begin
            action_s = ST_RUN;
        end
    end

    // State register and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            redirect_count_q <= 16'd0;
            stall_count_q    <= 16'd0;
            freeze_run_q     <= 16'd0;
            imem_timeout_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_count_q <= redirect_count_d;
            stall_count_q    <= stall_count_d;
            freeze_run_q     <= freeze_run_d;
            imem_timeout_q   <= imem_timeout_d;
        end
    end

    // Next-state: record the action, bump saturating counters, track the freeze run
    always_comb begin
        state_d          = action_s;
        redirect_count_d = redirect_count_q;
        stall_count_d    = stall_count_q;
        freeze_run_d     = 16'd0;
        imem_timeout_d   = imem_timeout_q;
        case (action_s)
            ST_REDIRECT: begin
                if (redirect_count_q != CNT_MAX) begin
                    redirect_count_d = redirect_count_q + 16'd1;
                end else begin
                    redirect_count_d = redirect_count_q;
                end
            end
            ST_STALL: begin
                if (stall_count_q != CNT_MAX) begin
                    stall_count_d = stall_count_q + 16'd1;
                end else begin
                    stall_count_d = stall_count_q;
                end
            end
            ST_FREEZE: begin
                if (freeze_run_q >= TIMEOUT_LIM) begin
                    freeze_run_d = TIMEOUT_LIM;
                end else begin
                    freeze_run_d = freeze_run_q + 16'd1;
                end
                // Timeout is sticky: once the run hits the limit it holds until reset
                if (freeze_run_d == TIMEOUT_LIM) begin
                    imem_timeout_d = 1'b1;
                end else begin
                    imem_timeout_d = imem_timeout_q;
                end
            end
            default: begin
                freeze_run_d = 16'd0;
            end
        endcase
    end

    // Output decode: pipeline controls from this cycle's action, forced quiet during reset
    always_comb begin
        out_pc_src      = 2'b00;
        out_pc_write    = 1'b0;
        out_if_id_write = 1'b0;
        out_if_id_flush = 1'b0;
        out_id_ex_flush = 1'b0;
        out_pipe_freeze = 1'b0;
        if (rst) begin
            out_pc_src = 2'b00;
        end else begin
            case (action_s)
                ST_FREEZE: begin
                    out_pipe_freeze = 1'b1;
                end
                ST_REDIRECT: begin
                    if (in_ex_jump_reg) begin
                        out_pc_src = 2'b11;
                    end else if (in_ex_jump) begin
                        out_pc_src = 2'b10;
                    end else begin
                        out_pc_src = 2'b01;
                    end
                    out_pc_write    = 1'b1;
                    out_if_id_write = 1'b1;
                    out_if_id_flush = 1'b1;
                    out_id_ex_flush = 1'b1;
                end
                ST_STALL: begin
                    out_id_ex_flush = 1'b1;
                end
                default: begin
                    out_pc_write    = 1'b1;
                    out_if_id_write = 1'b1;
                end
            endcase
        end
    end

    assign out_state          = state_q;
    assign out_redirect_count = redirect_count_q;
    assign out_stall_count    = stall_count_q;
    assign out_imem_timeout   = imem_timeout_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Scoreboard bench for pc_control_unit: a reference model pushes expectations, a monitor compares each cycle.
module tb_pc_control_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, taken, jump, jump_reg, mem_read, imem_ready;
    logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
    logic [1:0]  pc_src;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze;
    logic [1:0]  state;
    logic [15:0] redirect_count, stall_count;
    logic        imem_timeout;

    always #5 clk = ~clk;

    pc_control_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_ex_branch(branch), .in_ex_branch_taken(taken),
        .in_ex_jump(jump), .in_ex_jump_reg(jump_reg),
        .in_id_ex_mem_read(mem_read), .in_id_ex_rt(id_ex_rt),
        .in_if_id_rs(if_id_rs), .in_if_id_rt(if_id_rt),
        .in_imem_ready(imem_ready),
        .out_pc_src(pc_src), .out_pc_write(pc_write), .out_if_id_write(if_id_write),
        .out_if_id_flush(if_id_flush), .out_id_ex_flush(id_ex_flush),
        .out_pipe_freeze(pipe_freeze), .out_state(state),
        .out_redirect_count(redirect_count), .out_stall_count(stall_count),
        .out_imem_timeout(imem_timeout)
    );

    typedef struct {
        int pc_src; int pc_write; int if_id_write; int if_id_flush; int id_ex_flush;
        int freeze; int state; int red; int stall; int tout;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // reference model state: action names 0 RUN, 1 STALL, 2 REDIRECT, 3 FREEZE
    int m_state = 0, m_red = 0, m_stall = 0, m_frun = 0, m_tout = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit b, input bit t, input bit j, input bit jr,
                        input bit mr, input bit rdy, input int ert, input int rs, input int rt);
        exp_t e;
        bit ev_r, ev_l, ev_f;
        @(negedge clk);
        rst = r; branch = b; taken = t; jump = j; jump_reg = jr; mem_read = mr;
        imem_ready = rdy; id_ex_rt = 5'(ert); if_id_rs = 5'(rs); if_id_rt = 5'(rt);
        e = '{default: 0};
        if (r) begin
            m_state = 0; m_red = 0; m_stall = 0; m_frun = 0; m_tout = 0;
        end else begin
            ev_r = jr || j || (b && t);
            ev_l = mr && (ert != 0) && (ert == rs || ert == rt);
            ev_f = !rdy;
            if (ev_f) begin
                e.freeze = 1;
                m_state = 3;
                m_frun = (m_frun + 1 > TO) ? TO : m_frun + 1;
                if (m_frun == TO) m_tout = 1;
            end else begin
                m_frun = 0;
                if (ev_r) begin
                    e.pc_src = jr ? 3 : (j ? 2 : 1);
                    e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_flush = 1;
                    m_state = 2;
                    m_red = (m_red < 65535) ? m_red + 1 : 65535;
                end else if (ev_l) begin
                    e.id_ex_flush = 1;
                    m_state = 1;
                    m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
                end else begin
                    e.pc_write = 1; e.if_id_write = 1;
                    m_state = 0;
                end
            end
        end
        e.state = m_state; e.red = m_red; e.stall = m_stall; e.tout = m_tout;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    // Monitor: just after each rising edge, compare outputs against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_src", int'(pc_src), e.pc_src);
                chk("pc_write", int'(pc_write), e.pc_write);
                chk("if_id_write", int'(if_id_write), e.if_id_write);
                chk("if_id_flush", int'(if_id_flush), e.if_id_flush);
                chk("id_ex_flush", int'(id_ex_flush), e.id_ex_flush);
                chk("pipe_freeze", int'(pipe_freeze), e.freeze);
                chk("state", int'(state), e.state);
                chk("redirect_count", int'(redirect_count), e.red);
                chk("stall_count", int'(stall_count), e.stall);
                chk("imem_timeout", int'(imem_timeout), e.tout);
            end
        end
    end

    initial begin
        rst = 1'b1; branch = 1'b0; taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
        mem_read = 1'b0; imem_ready = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;

        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // taken branch, simultaneous redirects, not-taken branch
        step(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        // load-use, and the rt=0 exemption
        step(0, 0, 0, 0, 0, 1, 1, 5, 5, 9);
        step(0, 0, 0, 0, 0, 1, 1, 7, 1, 7);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        // freeze beats redirect, then redirect is taken once ready returns
        step(0, 0, 0, 1, 0, 1, 0, 5, 5, 5);
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        idle(1);

        // timeout: three freeze edges keep the flag low, the fourth raises it
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("timeout_after_3", int'(imem_timeout), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("timeout_after_4", int'(imem_timeout), 1);
        idle(3);
        @(posedge clk); #2;
        chk("timeout_sticky", int'(imem_timeout), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // randomized traffic with occasional reset pulses, including mid-freeze
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        // redirect counter saturation
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 65537; i++) step(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        @(posedge clk); #2;
        chk("redirect_saturated", int'(redirect_count), 65535);

        idle(2);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_control_unit.md
PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the consecutive instruction-memory-stall cycles before a timeout flag is raised (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_ex_branch  input  1  conditional branch in EXE.
REQ-005 SHALL have port in_ex_branch_taken  input  1  branch condition true in EXE.
REQ-006 SHALL have port in_ex_jump  input  1  J/JAL in EXE.
REQ-007 SHALL have port in_ex_jump_reg  input  1  JR in EXE.
REQ-008 SHALL have port in_id_ex_mem_read  input  1  load in EXE.
REQ-009 SHALL have port in_id_ex_rt  input  5  load destination register.
REQ-010 SHALL have port in_if_id_rs  input  5  rs of the instruction in ID.
REQ-011 SHALL have port in_if_id_rt  input  5  rt of the instruction in ID.
REQ-012 SHALL have port in_imem_ready  input  1  instruction memory has valid data this cycle.
REQ-013 SHALL have port out_pc_src  output  2  PC mux select: 00 PC+4, 01 branch, 10 jump, 11 jump-register.
REQ-014 SHALL have ports out_pc_write, out_if_id_write, out_if_id_flush, out_id_ex_flush, out_pipe_freeze  output  1 each  pipeline register controls.
REQ-015 SHALL have port out_state  output  2  registered action of the previous cycle: 00 RUN, 01 STALL, 10 REDIRECT, 11 FREEZE.
REQ-016 SHALL have ports out_redirect_count, out_stall_count  output  16 each  performance counters.
REQ-017 SHALL have port out_imem_timeout  output  1  sticky instruction-memory timeout flag.

Function
REQ-018 Event decode: R = jump_reg | jump | (branch & branch_taken); L = mem_read & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt); F = !imem_ready.
REQ-019 Priority F > R > L > normal; all control outputs are combinational from the current inputs, with zero-cycle latency.
REQ-020 F: pipe_freeze=1, pc_write=0, if_id_write=0, both flushes=0, pc_src=00; a redirect or stall is deferred because EXE holds its contents.
REQ-021 R (F=0): pc_src = 11 if jump_reg, else 10 if jump, else 01; pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, pipe_freeze=0.
REQ-022 Multiple redirect sources asserted together: jump_reg > jump > taken branch; branch with taken=0 is not a redirect.
REQ-023 L (F=0, R=0): pc_src=00, pc_write=0, if_id_write=0, id_ex_flush=1 (bubble), if_id_flush=0.
REQ-024 Normal: pc_src=00, pc_write=1, if_id_write=1, flushes=0, pipe_freeze=0.
REQ-025 State register: on each edge it loads the action taken that cycle (FREEZE/REDIRECT/STALL/RUN) and drives out_state.
REQ-026 out_redirect_count increments on each edge with R & !F; out_stall_count increments on each edge with L & !F & !R; both saturate at 0xFFFF.
REQ-027 A freeze-run counter increments on each edge with F=1, clears on an edge with F=0, and saturates at TIMEOUT_CYCLES.
REQ-028 When the freeze-run counter reaches TIMEOUT_CYCLES, out_imem_timeout is set on that edge and stays 1 until reset, regardless of later imem_ready.

Reset
REQ-029 While rst=1, all sequential state clears asynchronously: out_state=00, both counters 0, freeze-run counter 0, out_imem_timeout=0.
REQ-030 While rst=1, outputs are forced: pc_src=00, pc_write=0, if_id_write=0, flushes=0, pipe_freeze=0.
REQ-031 Reset asserted mid-freeze or mid-redirect SHALL take effect immediately, with no deferred action replayed after deassertion.
REQ-032 On the first edge after rst deasserts, normal decode per REQ-018..028 applies.

Verification
REQ-033 Taken branch: branch=1, taken=1, imem_ready=1 -> pc_src=01, both flushes=1 that cycle; out_state=10 and redirect_count=1 after the edge.
REQ-034 Simultaneous jump_reg=1, jump=1, branch&taken=1 -> pc_src=11; branch=1, taken=0 alone -> pc_src=00, no flush.
REQ-035 Load-use: mem_read=1, id_ex_rt=5, if_id_rs=5 -> pc_write=0, if_id_write=0, id_ex_flush=1, stall_count +1. Same case with id_ex_rt=0 -> no stall.
REQ-036 Freeze beats redirect: imem_ready=0 with jump=1 -> pc_write=0, pipe_freeze=1, no flush, counters unchanged. When imem_ready returns to 1 -> pc_src=10, redirect counted once.
REQ-037 Timeout with TIMEOUT_CYCLES=4: imem_ready=0 for 3 edges -> flag 0; 4th edge -> flag 1; flag stays 1 after ready returns; rst pulse clears it.
REQ-038 Saturation: drive 65537 taken branches -> out_redirect_count holds 0xFFFF.
